// File: rtl/des_pkg.sv
// des_pkg: shared DES key-schedule definitions.
//   - state_e        : schedule controller states
//   - SHIFT_ENC/DEC  : per-round rotation amounts (encrypt = left, decrypt = right)
//   - PC1_TAB/PC2_TAB: FIPS 46-3 permuted-choice tables, 1-based DES bit numbers
//   - pc1()          : 64-bit key -> 56-bit C|D (parity bits dropped)
//   - rotl28/rotr28  : rotate a 28-bit half by 0, 1 or 2
//   - rot_cd()       : rotate both halves independently in one direction
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SHIFT_ENC [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Decrypt round 0 is unrotated: the encrypt schedule rotates 28 in total,
  // so K16 sits on the original PC-1 alignment.
  localparam logic [1:0] SHIFT_DEC [16] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // DES bit b (1 = MSB) lives at key[64-b]; output bit i lands at cd[55-i].
  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      cd[6'(55 - i)] = key[6'(64 - PC1_TAB[i])];
    end
    return cd;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [55:0] rot_cd(input logic [55:0] cd, input logic [1:0] n,
                                         input logic right);
    if (right) return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    else       return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// des_pc2: DES permuted choice 2, purely combinational.
//   cd     in  56 : C (cd[55:28]) | D (cd[27:0]), cd[55] = C|D bit 1
//   subkey out 48 : round subkey, subkey[47] = PC-2 bit 1
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  always_comb begin
    subkey = '0;
    for (int j = 0; j < 48; j++) begin
      subkey[6'(47 - j)] = cd[6'(56 - PC2_TAB[j])];
    end
  end

  // C|D bits 9,18,22,25,35,38,43,54 are never selected by PC-2.
  logic unused_dropped;
  assign unused_dropped = ^{cd[47], cd[38], cd[34], cd[31], cd[21], cd[18], cd[13], cd[2]};

endmodule

// File: rtl/des_subkey_gen.sv
// des_subkey_gen: iterative DES key schedule, one 48-bit subkey per handshake.
//   clk, rstn         : clock, async active-low reset
//   start/decrypt/key : request a schedule (sampled only when idle)
//   subkey/round      : presented subkey and its issue index, qualified by subkey_valid
//   subkey_ready      : consumer accepts the presented subkey
//   busy/done         : schedule in progress / one-cycle completion pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; C/D hold last value
// ST_RUN  | presenting subkey[round]; advance on valid & ready
// ST_DONE | one-cycle done pulse, start ignored
module des_subkey_gen
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        decrypt,
  input  logic [63:0] key,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  state_e      state_q, state_d;
  logic [55:0] cd_q, cd_d;
  logic [3:0]  round_q, round_d;
  logic        mode_q, mode_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [3:0]  round_inc;
  logic [1:0]  shift_next;

  assign round_inc  = round_q + 4'd1;
  assign shift_next = mode_q ? SHIFT_DEC[round_inc] : SHIFT_ENC[round_inc];

  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    round_d = round_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = decrypt;
          round_d = 4'd0;
          cd_d    = rot_cd(pc1(key), decrypt ? SHIFT_DEC[0] : SHIFT_ENC[0], decrypt);
        end
      end
      ST_RUN: begin
        if (subkey_ready) begin
          if (round_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_inc;
            cd_d    = rot_cd(cd_q, shift_next, mode_q);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cd_q    <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd     (cd_q),
    .subkey (subkey)
  );

  assign subkey_valid = valid_q;
  assign busy         = valid_q;
  assign done         = done_q;
  assign round        = round_q;

  // Parity bits of the key carry no schedule information.
  logic unused_parity;
  assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

endmodule

// File: tb/tb_des_subkey_gen.sv
module tb_des_subkey_gen;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;

  localparam logic [63:0] K_STD = 64'h133457799BBCDFF1;
  localparam logic [63:0] K_PAR = 64'h123456789ABCDEF0;

  localparam int TB_PC1 [56] = '{
    57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4
  };
  localparam int TB_PC2 [48] = '{
    14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32
  };
  localparam int TB_SH [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        decrypt;
  logic [63:0] key;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready = 1'b1;
  logic [3:0]  round;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int ready_pct = 100;

  des_subkey_gen dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .decrypt      (decrypt),
    .key          (key),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: Ki = PC2(C0 <<< s, D0 <<< s) with s the cumulative shift through round i.
  function automatic logic [47:0] ref_enc(input logic [63:0] k, input int r);
    logic [27:0] c, d;
    logic [55:0] cd;
    logic [47:0] s;
    int tot;
    for (int i = 0; i < 28; i++) begin
      c[27-i] = k[64-TB_PC1[i]];
      d[27-i] = k[64-TB_PC1[i+28]];
    end
    tot = 0;
    for (int i = 0; i <= r; i++) tot += TB_SH[i];
    for (int i = 0; i < tot % 28; i++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
    end
    cd = {c, d};
    for (int j = 0; j < 48; j++) s[47-j] = cd[56-TB_PC2[j]];
    return s;
  endfunction

  function automatic logic [47:0] ref_key(input logic [63:0] k, input bit dec, input int idx);
    return dec ? ref_enc(k, 15 - idx) : ref_enc(k, idx);
  endfunction

  // Transaction-level model of the schedule: phase, issue index, latched request.
  int          m_phase = P_IDLE;
  int          m_idx = 0;
  logic [63:0] m_key = '0;
  bit          m_dec = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_phase <= P_IDLE;
      m_idx   <= 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase <= P_RUN;
          m_idx   <= 0;
          m_key   <= key;
          m_dec   <= decrypt;
        end
        P_RUN: if (subkey_ready) begin
          if (m_idx == 15) m_phase <= P_DONE;
          else m_idx <= m_idx + 1;
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  logic [47:0] obs[$];
  bit          stall_prev = 1'b0;
  logic [47:0] stall_key = '0;

  always @(negedge clk) begin
    chk("valid", {63'd0, subkey_valid}, {63'd0, m_phase == P_RUN});
    chk("busy", {63'd0, busy}, {63'd0, m_phase == P_RUN});
    chk("done", {63'd0, done}, {63'd0, m_phase == P_DONE});
    if (m_phase == P_RUN) begin
      chk("subkey", {16'd0, subkey}, {16'd0, ref_key(m_key, m_dec, m_idx)});
      chk("round", {60'd0, round}, 64'(m_idx));
    end
    if (stall_prev && subkey_valid) chk("stall_hold", {16'd0, subkey}, {16'd0, stall_key});
    stall_prev = subkey_valid && !subkey_ready;
    stall_key  = subkey;
    if (subkey_valid && subkey_ready) obs.push_back(subkey);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      subkey_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Accept a schedule, optionally poke start mid-run, wait (bounded) for done.
  task automatic run_sched(input logic [63:0] k, input logic dec, input int poke, output int cyc);
    obs.delete();
    @(posedge clk); #1;
    start = 1'b1; key = k; decrypt = dec;
    @(posedge clk); #1;
    start = 1'b0; key = {$urandom, $urandom}; decrypt = ~dec;
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke) begin
        start = 1'b1; key = K_PAR; decrypt = ~dec;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 64'(cyc), 64'd0);
  endtask

  logic [47:0] enc_seq[$];
  logic [47:0] par_seq[$];
  int cyc;

  initial begin
    rstn = 1'b0; start = 1'b0; decrypt = 1'b0; key = '0;

    chk("model_k1",  {16'd0, ref_key(K_STD, 0, 0)},  64'h1B02EFFC7072);
    chk("model_k2",  {16'd0, ref_key(K_STD, 0, 1)},  64'h79AED9DBC9E5);
    chk("model_k16", {16'd0, ref_key(K_STD, 0, 15)}, 64'hCB3D8B0E17F5);
    chk("model_d0",  {16'd0, ref_key(K_STD, 1, 0)},  64'hCB3D8B0E17F5);

    #23;
    chk("rst_valid", {63'd0, subkey_valid}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_done",  {63'd0, done}, 64'd0);
    chk("rst_round", {60'd0, round}, 64'd0);
    chk("rst_subkey", {16'd0, subkey}, 64'd0);
    #4 rstn = 1'b1;

    // Encrypt, no backpressure
    run_sched(K_STD, 1'b0, -1, cyc);
    chk("enc_latency", 64'(cyc), 64'd16);
    chk("enc_count", 64'(obs.size()), 64'd16);
    if (obs.size() == 16) begin
      chk("enc_r0",  {16'd0, obs[0]},  64'h1B02EFFC7072);
      chk("enc_r1",  {16'd0, obs[1]},  64'h79AED9DBC9E5);
      chk("enc_r15", {16'd0, obs[15]}, 64'hCB3D8B0E17F5);
    end
    enc_seq = obs;

    // Decrypt is the reversed encrypt sequence
    run_sched(K_STD, 1'b1, -1, cyc);
    chk("dec_count", 64'(obs.size()), 64'd16);
    if (obs.size() == 16 && enc_seq.size() == 16) begin
      chk("dec_r0",  {16'd0, obs[0]},  64'hCB3D8B0E17F5);
      chk("dec_r15", {16'd0, obs[15]}, 64'h1B02EFFC7072);
      for (int i = 0; i < 16; i++) chk("dec_reverse", {16'd0, obs[i]}, {16'd0, enc_seq[15-i]});
    end

    // Backpressure
    ready_pct = 40;
    run_sched(K_STD, 1'b0, -1, cyc);
    chk("bp_count", 64'(obs.size()), 64'd16);
    if (obs.size() == 16 && enc_seq.size() == 16)
      for (int i = 0; i < 16; i++) chk("bp_seq", {16'd0, obs[i]}, {16'd0, enc_seq[i]});
    ready_pct = 100;

    // start during RUN is ignored
    run_sched(K_STD, 1'b0, 5, cyc);
    chk("poke_latency", 64'(cyc), 64'd16);
    chk("poke_count", 64'(obs.size()), 64'd16);
    if (obs.size() == 16 && enc_seq.size() == 16)
      for (int i = 0; i < 16; i++) chk("poke_seq", {16'd0, obs[i]}, {16'd0, enc_seq[i]});

    // Async reset at round 7
    obs.delete();
    @(posedge clk); #1;
    start = 1'b1; key = K_STD; decrypt = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(subkey_valid && round == 4'd7) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reach_round7", {60'd0, round}, 64'd7);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", {63'd0, subkey_valid}, 64'd0);
    chk("arst_busy",  {63'd0, busy}, 64'd0);
    chk("arst_done",  {63'd0, done}, 64'd0);
    chk("arst_round", {60'd0, round}, 64'd0);
    chk("arst_subkey", {16'd0, subkey}, 64'd0);
    #10 rstn = 1'b1;
    run_sched(K_STD, 1'b0, -1, cyc);
    chk("post_rst_count", 64'(obs.size()), 64'd16);
    if (obs.size() > 0) chk("post_rst_r0", {16'd0, obs[0]}, 64'h1B02EFFC7072);

    // Parity insensitivity
    run_sched(K_PAR, 1'b0, -1, cyc);
    par_seq = obs;
    run_sched(K_PAR ^ 64'h0101010101010101, 1'b0, -1, cyc);
    chk("par_count", 64'(obs.size()), 64'(par_seq.size()));
    if (obs.size() == 16 && par_seq.size() == 16)
      for (int i = 0; i < 16; i++) chk("parity_seq", {16'd0, obs[i]}, {16'd0, par_seq[i]});

    // Random keys, modes and backpressure against the model
    ready_pct = 60;
    for (int n = 0; n < 8; n++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), -1, cyc);
      chk("rand_count", 64'(obs.size()), 64'd16);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
